seg_scan_scroller: RTL and testbench
====================================

Name: seg_scan_scroller

Overview:
Parametrised seven-segment scan driver and the next generation of the fixed 8-digit track viewer.
- Takes a buffer of pre-decoded 8-bit segment patterns, snapshots it on a load strobe, and time-multiplexes it onto NUM_DIGITS digits at a programmable scan rate.
- Adds per-digit blinking and a circular scroll mode for content longer than the display.
- Sits between the music/view decoders and the board's seg_en/seg_out pins.

Parameters:
- NUM_DIGITS, 8: physical digits driven, 1..8.
- BUF_LEN, 12: pattern entries held in the snapshot buffer; must be >= NUM_DIGITS.
- SCAN_DIV, 2: EGO1_Clock cycles per digit slot; 1 means advance every cycle.
- BLINK_FRAMES, 2: full frames per blink half-period.
- SCROLL_FRAMES, 1: full frames per scroll step.

Ports:
- EGO1_Clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe; captures digits_in into the buffer.
- digits_in  in  8*BUF_LEN  entry k = digits_in[8k+7:8k]; entry 0 is leftmost.
- mode  in  1  0 = static window at entry 0; 1 = scroll.
- blink_mask  in  NUM_DIGITS  bit NUM_DIGITS-1-i set means digit slot i blinks (slot 0 is leftmost).
- seg_en  out  NUM_DIGITS  one-hot, active-high digit enable; MSB is the leftmost digit.
- seg_out  out  16  {pat, pat}: the same pattern on both segment groups.
- scroll_pos  out  log2(BUF_LEN)  current window start entry.
- frame_done  out  1  one-cycle pulse when the scan wraps.

Behaviour:
- All state updates on the rising edge of EGO1_Clock. reset is synchronous, active-high, and overrides everything.
- Reset values:
  - prescaler = 0, scan_idx = 0, buffer = all-zero.
  - scroll_pos = 0, blink_phase = 0, blink/scroll frame counters = 0.
  - seg_en = 0, seg_out = 0, frame_done = 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1; tick = (prescaler == SCAN_DIV-1).
  - On tick, the prescaler returns to 0 and scan_idx advances, wrapping NUM_DIGITS-1 -> 0.
- Frame end:
  - A tick with scan_idx == NUM_DIGITS-1 is frame end.
  - frame_done is registered high for exactly the cycle after frame end.
- Digit select:
  - Slot i shows entry e = (scroll_pos + i) mod BUF_LEN.
  - Wrap is circular: entry BUF_LEN-1 is followed by entry 0.
- Blink:
  - blink_phase toggles after every BLINK_FRAMES frame ends.
  - While blink_phase = 1, a slot with its mask bit set outputs pat = 8'h00.
  - seg_en still asserts for that slot, so scan timing is unchanged.
- Output registers, every non-reset cycle:
  - seg_en <= one-hot bit (NUM_DIGITS-1-scan_idx).
  - seg_out <= {pat, pat} for slot scan_idx.
  - This gives 1-cycle latency from scan_idx; the first post-reset cycle drives slot 0.
- Scroll:
  - With mode = 1, scroll_pos increments after every SCROLL_FRAMES frame ends, wrapping BUF_LEN-1 -> 0.
  - With mode = 0, scroll_pos is forced to 0 on the next edge and the scroll counter clears.
- Load:
  - The whole buffer is captured from digits_in on the edge where load = 1.
  - scroll_pos and the scroll counter clear to 0.
  - Scan and blink timing are not disturbed. The display never reads digits_in directly, so no tearing.
- Simultaneous events:
  - load together with a scroll step: load wins, scroll_pos = 0.
  - load together with frame end: frame_done still pulses; blink still advances.
  - reset together with load: reset wins, buffer is zero.
- Reset mid-frame: outputs blank on the next edge and scanning restarts at slot 0.

Test Plan:
1. Reset for 3 cycles, then release with load = 0 -> seg_en = 0 and seg_out = 0 during reset. First post-reset cycle: seg_en = 8'h80, seg_out = 16'h0000. seg_en then walks 80, 40, ..., 01, holding each for 2 cycles; frame_done pulses once every 16 cycles.
2. digits_in entry k = 8'h10+k, load pulse, mode = 0 -> slot 0 shows 16'h1010, slot 7 shows 16'h1717. scroll_pos stays 0.
3. Same load, mode = 1, SCROLL_FRAMES = 1 -> after 1 frame, slot 0 = 8'h11. After 11 frames, slot 0 = 8'h1B and slot 1 = 8'h10 (wrap). After 12 frames, scroll_pos = 0.
4. blink_mask = 8'b1000_0001 -> in frames 0-1, slots 0 and 7 show their patterns. In frames 2-3, those slots show 16'h0000 with seg_en still 8'h80 / 8'h01; the other slots are unchanged.
5. In mode = 1 at scroll_pos = 5, assert load on the frame-end cycle with new data 8'hA0+k -> scroll_pos = 0 and slot 0 shows 16'hA0A0. frame_done still pulses.
6. Assert reset mid-frame at scan_idx = 4 -> seg_en = 0 on the next edge; after release, scanning restarts at 8'h80 and the buffer reads all-zero.

Source files
------------

// File: rtl/seg_scan_scroller.sv
// Seven-segment scan driver: snapshots a pattern buffer on load and multiplexes a
// (optionally scrolling, optionally blinking) window of it onto NUM_DIGITS digits.
module seg_scan_scroller #(
  parameter int NUM_DIGITS    = 8,
  parameter int BUF_LEN       = 12,
  parameter int SCAN_DIV      = 2,
  parameter int BLINK_FRAMES  = 2,
  parameter int SCROLL_FRAMES = 1,
  localparam int PW = (BUF_LEN > 1) ? $clog2(BUF_LEN) : 1
) (
  input  logic                    EGO1_Clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [8*BUF_LEN-1:0]    digits_in,
  input  logic                    mode,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [NUM_DIGITS-1:0]   seg_en,
  output logic [15:0]             seg_out,
  output logic [PW-1:0]           scroll_pos,
  output logic                    frame_done
);

  localparam int PS_W = (SCAN_DIV > 1)      ? $clog2(SCAN_DIV)      : 1;
  localparam int SI_W = (NUM_DIGITS > 1)    ? $clog2(NUM_DIGITS)    : 1;
  localparam int BC_W = (BLINK_FRAMES > 1)  ? $clog2(BLINK_FRAMES)  : 1;
  localparam int SC_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

  logic [PS_W-1:0]       presc_q, presc_d;
  logic [SI_W-1:0]       scan_idx_q, scan_idx_d;
  logic [7:0]            buf_q [BUF_LEN];
  logic [7:0]            buf_d [BUF_LEN];
  logic [PW-1:0]         scroll_pos_q, scroll_pos_d;
  logic [SC_W-1:0]       scroll_cnt_q, scroll_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [BC_W-1:0]       blink_cnt_q, blink_cnt_d;
  logic [NUM_DIGITS-1:0] seg_en_q, seg_en_d;
  logic [15:0]           seg_out_q, seg_out_d;
  logic                  frame_done_q, frame_done_d;

  logic                  tick;
  logic                  frame_end;
  logic [PW:0]           entry_sum;
  logic [PW-1:0]         entry;
  logic [SI_W-1:0]       slot_bit;
  logic [7:0]            pat;

  always_comb begin
    presc_d       = presc_q;
    scan_idx_d    = scan_idx_q;
    buf_d         = buf_q;
    scroll_pos_d  = scroll_pos_q;
    scroll_cnt_d  = scroll_cnt_q;
    blink_phase_d = blink_phase_q;
    blink_cnt_d   = blink_cnt_q;
    seg_en_d      = '0;

    tick      = (presc_q == PS_W'(SCAN_DIV - 1));
    frame_end = tick && (scan_idx_q == SI_W'(NUM_DIGITS - 1));

    if (tick) begin
      presc_d    = '0;
      scan_idx_d = frame_end ? '0 : scan_idx_q + 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end

    if (frame_end) begin
      if (blink_cnt_q == BC_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end

    // Load outranks a coincident scroll step; mode 0 pins the window at entry 0.
    if (load) begin
      for (int k = 0; k < BUF_LEN; k++) buf_d[k] = digits_in[8*k +: 8];
      scroll_pos_d = '0;
      scroll_cnt_d = '0;
    end else if (!mode) begin
      scroll_pos_d = '0;
      scroll_cnt_d = '0;
    end else if (frame_end) begin
      if (scroll_cnt_q == SC_W'(SCROLL_FRAMES - 1)) begin
        scroll_cnt_d = '0;
        scroll_pos_d = (scroll_pos_q == PW'(BUF_LEN - 1)) ? '0 : scroll_pos_q + 1'b1;
      end else begin
        scroll_cnt_d = scroll_cnt_q + 1'b1;
      end
    end

    // Window start plus slot is below 2*BUF_LEN, so one subtract wraps it.
    entry_sum = {1'b0, scroll_pos_q} + (PW+1)'(scan_idx_q);
    if (entry_sum >= (PW+1)'(BUF_LEN)) entry_sum = entry_sum - (PW+1)'(BUF_LEN);
    entry = entry_sum[PW-1:0];

    slot_bit = SI_W'(NUM_DIGITS - 1) - scan_idx_q;
    pat      = (blink_phase_q && blink_mask[slot_bit]) ? 8'h00 : buf_q[entry];

    seg_en_d[slot_bit] = 1'b1;
    seg_out_d          = {pat, pat};
    frame_done_d       = frame_end;
  end

  always_ff @(posedge EGO1_Clock) begin
    if (reset) begin
      presc_q       <= '0;
      scan_idx_q    <= '0;
      for (int k = 0; k < BUF_LEN; k++) buf_q[k] <= 8'h00;
      scroll_pos_q  <= '0;
      scroll_cnt_q  <= '0;
      blink_phase_q <= 1'b0;
      blink_cnt_q   <= '0;
      seg_en_q      <= '0;
      seg_out_q     <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      scan_idx_q    <= scan_idx_d;
      buf_q         <= buf_d;
      scroll_pos_q  <= scroll_pos_d;
      scroll_cnt_q  <= scroll_cnt_d;
      blink_phase_q <= blink_phase_d;
      blink_cnt_q   <= blink_cnt_d;
      seg_en_q      <= seg_en_d;
      seg_out_q     <= seg_out_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign seg_en     = seg_en_q;
  assign seg_out    = seg_out_q;
  assign scroll_pos = scroll_pos_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_scroller.sv
// Bench for seg_scan_scroller: directed scenarios plus random traffic, checked
// against a model that derives scan position and timing from a cycle count.
module tb_seg_scan_scroller;

  localparam int ND = 8;
  localparam int BL = 12;
  localparam int SD = 2;
  localparam int BF = 2;
  localparam int SF = 1;
  localparam int FRAME = SD * ND;

  logic            clk = 1'b0;
  logic            reset;
  logic            load;
  logic [8*BL-1:0] digits_in;
  logic            mode;
  logic [ND-1:0]   blink_mask;
  logic [ND-1:0]   seg_en;
  logic [15:0]     seg_out;
  logic [3:0]      scroll_pos;
  logic            frame_done;

  seg_scan_scroller #(
    .NUM_DIGITS(ND), .BUF_LEN(BL), .SCAN_DIV(SD),
    .BLINK_FRAMES(BF), .SCROLL_FRAMES(SF)
  ) dut (
    .EGO1_Clock(clk), .reset(reset), .load(load), .digits_in(digits_in),
    .mode(mode), .blink_mask(blink_mask), .seg_en(seg_en), .seg_out(seg_out),
    .scroll_pos(scroll_pos), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Model: c = non-reset edges since reset, steps = frame ends counted in scroll mode
  int         c;
  int         steps;
  logic [7:0] mbuf [BL];
  int         exp_en, exp_out, exp_fd, exp_pos;

  task automatic model_edge();
    int slot, pos, phase, e;
    logic [7:0] pat;
    if (reset) begin
      c = 0; steps = 0;
      for (int k = 0; k < BL; k++) mbuf[k] = 8'h00;
      exp_en = 0; exp_out = 0; exp_fd = 0;
    end else begin
      slot  = (c / SD) % ND;
      pos   = (steps / SF) % BL;
      phase = ((c / FRAME) / BF) % 2;
      e     = (pos + slot) % BL;
      pat   = (phase == 1 && blink_mask[ND-1-slot]) ? 8'h00 : mbuf[e];
      exp_en  = 1 << (ND - 1 - slot);
      exp_out = {16'h0, pat, pat};
      c++;
      exp_fd = (c % FRAME == 0) ? 1 : 0;
      if (load) begin
        for (int k = 0; k < BL; k++) mbuf[k] = digits_in[8*k +: 8];
        steps = 0;
      end else if (!mode) begin
        steps = 0;
      end else if (exp_fd == 1) begin
        steps = (steps + 1) % (SF * BL);
      end
    end
    exp_pos = (steps / SF) % BL;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("seg_en",     32'(seg_en),     32'(exp_en));
    check("seg_out",    32'(seg_out),    32'(exp_out));
    check("frame_done", 32'(frame_done), 32'(exp_fd));
    check("scroll_pos", 32'(scroll_pos), 32'(exp_pos));
  endtask

  task automatic fill_data(input logic [7:0] base);
    for (int k = 0; k < BL; k++) digits_in[8*k +: 8] = base + 8'(k);
  endtask

  initial begin
    bit found;
    reset = 1'b1; load = 1'b0; mode = 1'b0; blink_mask = '0; digits_in = '0;
    c = 0; steps = 0;

    // Reset, then first walk over a blank buffer
    repeat (3) step();
    reset = 1'b0;
    step();
    check("first_en_80", 32'(seg_en), 32'h80);
    repeat (2 * FRAME) step();

    // Static window with a known buffer
    fill_data(8'h10);
    load = 1'b1; step(); load = 1'b0;
    repeat (FRAME + 2) step();

    // Scroll through a full wrap
    mode = 1'b1;
    repeat (13 * FRAME) step();

    // Blink first and last slots over several half-periods
    mode = 1'b0;
    blink_mask = 8'b1000_0001;
    repeat (5 * FRAME) step();
    blink_mask = '0;

    // Load coinciding with a frame end at window start 5
    mode = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 * FRAME && !found; i++) begin
      if (steps == 5 && ((c + 1) % FRAME) == 0) found = 1'b1;
      else step();
    end
    check("t5_reached", 32'(found), 32'h1);
    fill_data(8'hA0);
    load = 1'b1; step(); load = 1'b0;
    check("t5_pos0",  32'(scroll_pos), 32'h0);
    check("t5_fdone", 32'(frame_done), 32'h1);
    repeat (FRAME + 2) step();

    // Reset mid-frame, then rescan over an empty buffer
    while ((c / SD) % ND != 4) step();
    reset = 1'b1; step();
    check("t6_blank", 32'(seg_en), 32'h0);
    reset = 1'b0; step();
    check("t6_restart", 32'(seg_en), 32'h80);
    repeat (FRAME) step();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      load  = ($urandom_range(23) == 0);
      reset = ($urandom_range(399) == 0);
      if (load) for (int k = 0; k < BL; k++) digits_in[8*k +: 8] = 8'($urandom);
      if ($urandom_range(199) == 0) mode = ~mode;
      if ($urandom_range(149) == 0) blink_mask = ND'($urandom);
      step();
    end
    load = 1'b0; reset = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
